// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit period and receiver state encoding.
// The RX_PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;
  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_RX_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;
endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with a parity_err pulse.
// Samples each bit at its centre, counted from the centre of the start bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  rx_state_t            state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [2:0]           bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 rx_valid_reg, rx_valid_next;
  logic                 frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit_reg, parity_bit_next;
  logic                 parity_err_reg, parity_err_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= RX_IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      data_reg      <= data_next;
      rx_valid_reg  <= rx_valid_next;
      frame_err_reg <= frame_err_next;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= parity_bit_next;
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + 1'b1;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    data_next      = data_reg;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bit_next = parity_bit_reg;
    parity_err_next = 1'b0;
`endif
    case (state_reg)
      RX_IDLE: begin
        cnt_next     = '0;
        bit_idx_next = '0;
        if (!rx_s) state_next = RX_START;
      end
      RX_START: begin
        // A start bit that is gone by its centre is treated as a line glitch.
        if (cnt_reg == HALF_M1) begin
          cnt_next   = '0;
          state_next = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_reg == FULL_M1) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift_reg[DATA_BITS-1:1]};
          bit_idx_next = bit_idx_reg + 1'b1;
          if (bit_idx_reg == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_next = RX_PARITY;
`else
            state_next = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (cnt_reg == FULL_M1) begin
          cnt_next        = '0;
          parity_bit_next = rx_s;
          state_next      = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        // Leave at mid stop bit so the next start edge is never missed.
        if (cnt_reg == FULL_M1) begin
          cnt_next   = '0;
          state_next = RX_IDLE;
          if (!rx_s) frame_err_next = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (parity_bit_reg != ^shift_reg) parity_err_next = 1'b1;
`endif
          else begin
            rx_valid_next = 1'b1;
            data_next     = shift_reg;
          end
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign data      = data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign rx_busy   = (state_reg != RX_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (CLKS_PER_BIT=10); the model predicts each frame's
// outcome and the busy window / pulse cycle from the line waveform the bench drives.
module tb_uart_rx;
  localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif

  typedef enum {EV_VALID, EV_FERR, EV_PERR, EV_NONE, EV_ABORT} kind_t;
  typedef struct {
    kind_t      kind;
    logic [7:0] data;
    int         busy_start;
    int         edge_at;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       rx_valid, rx_busy, frame_err, parity_err;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   nvalid = 0;
  bit   chk_en = 1'b0;
  ev_t  evq[$];
  logic [7:0] exp_data = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives a frame, sending only the first nfull bit periods (nfull >= frame length sends all).
  // Edge k is the first clock edge that sees the start bit; the stop-bit centre reaches the
  // FSM two synchronizer edges later and the pulse shows in the cycle after that edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic par_flip, input int nfull);
    logic [10:0] bits;
    int nb, k;
    ev_t ev;
    nb = 10 + NPAR;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    if (NPAR == 1) bits[9] = (^d) ^ par_flip;
    bits[nb-1] = stop_bit;
    k = cyc + 1;
    ev.data       = d;
    ev.busy_start = k + 2;
    ev.edge_at    = k + CPB * (nb - 1) + CPB / 2 + 2;
    if (!stop_bit) ev.kind = EV_FERR;
    else if (NPAR == 1 && par_flip) ev.kind = EV_PERR;
    else ev.kind = EV_VALID;
    evq.push_back(ev);
    // A low stop bit is still low when the receiver re-arms, so it looks like a
    // short start pulse that is rejected at its centre.
    if (!stop_bit && nfull >= nb) begin
      ev.kind       = EV_NONE;
      ev.busy_start = ev.edge_at + 1;
      ev.edge_at    = ev.edge_at + 1 + CPB / 2;
      evq.push_back(ev);
    end
    for (int i = 0; i < nb && i < nfull; i++) begin
      rx = bits[i];
      tick(CPB);
    end
  endtask

  task automatic glitch(input int low_cycles);
    ev_t ev;
    int k;
    k = cyc + 1;
    ev.kind       = EV_NONE;
    ev.data       = 8'h00;
    ev.busy_start = k + 2;
    ev.edge_at    = k + 2 + CPB / 2;
    evq.push_back(ev);
    rx = 1'b0;
    tick(low_cycles);
    rx = 1'b1;
  endtask

  task automatic abort_reset();
    ev_t ev;
    ev = evq.pop_back();
    ev.kind    = EV_ABORT;
    ev.edge_at = cyc + 1;
    evq.push_back(ev);
    reset = 1'b1;
    rx = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // Cycle-by-cycle comparison against the event model.
  initial begin
    logic exp_valid, exp_ferr, exp_perr, exp_busy;
    wait (chk_en);
    forever begin
      @(negedge clk);
      exp_valid = 1'b0; exp_ferr = 1'b0; exp_perr = 1'b0; exp_busy = 1'b0;
      if (evq.size() > 0) begin
        if (cyc >= evq[0].busy_start && cyc < evq[0].edge_at) exp_busy = 1'b1;
        if (cyc == evq[0].edge_at) begin
          case (evq[0].kind)
            EV_VALID: begin exp_valid = 1'b1; exp_data = evq[0].data; end
            EV_FERR:  exp_ferr = 1'b1;
            EV_PERR:  exp_perr = 1'b1;
            EV_ABORT: exp_data = 8'h00;
            default:  ;
          endcase
          void'(evq.pop_front());
        end
      end
      if (rx_valid === 1'b1) nvalid++;
      check("rx_valid", 32'(rx_valid), 32'(exp_valid));
      check("frame_err", 32'(frame_err), 32'(exp_ferr));
      check("parity_err", 32'(parity_err), 32'(exp_perr));
      check("rx_busy", 32'(rx_busy), 32'(exp_busy));
      check("data", 32'(data), 32'(exp_data));
    end
  end

  initial begin
    tick(3);
    reset = 1'b0;
    chk_en = 1'b1;
    tick(5);

    send_frame(8'hA5, 1'b1, 1'b0, 99);
    tick(5);
    check("lit_data_a5", 32'(data), 32'h0000_00A5);

    glitch(3);
    tick(20);
    check("lit_data_glitch", 32'(data), 32'h0000_00A5);

    send_frame(8'h3C, 1'b0, 1'b0, 99);
    rx = 1'b1;
    tick(20);
    check("lit_data_ferr", 32'(data), 32'h0000_00A5);

    send_frame(8'h55, 1'b1, 1'b0, 99);
    send_frame(8'hFF, 1'b1, 1'b0, 99);
    tick(5);
    check("lit_data_ff", 32'(data), 32'h0000_00FF);

    // Abort during data bit 4 (start + bits 0..3 complete).
    send_frame(8'hC3, 1'b1, 1'b0, 5);
    rx = 1'b0;
    tick(4);
    abort_reset();
    check("lit_data_reset", 32'(data), 32'h0000_0000);
    tick(10);
    send_frame(8'h81, 1'b1, 1'b0, 99);
    tick(5);
    check("lit_data_81", 32'(data), 32'h0000_0081);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 99);
    tick(5);
    check("lit_data_perr", 32'(data), 32'h0000_0081);
    send_frame(8'h07, 1'b1, 1'b0, 99);
    tick(5);
    check("lit_data_07", 32'(data), 32'h0000_0007);
`endif

    tick(10);
    check("events_pending", 32'(evq.size()), 32'd0);
    check("valid_count", 32'(nvalid), 32'(4 + NPAR));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 16, clk cycles per serial bit; must be even and >= 4.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: rx  input  1  asynchronous serial line; idle high.
REQ-005 SHALL have port: data  output  8  last received byte.
REQ-006 SHALL have port: rx_valid  output  1  one-cycle pulse; the byte on data is new.
REQ-007 SHALL have port: rx_busy  output  1  high while a frame is in progress.
REQ-008 SHALL have port: frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 SHALL have port: parity_err  output  1  one-cycle pulse; parity mismatch (see Configuration).

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all further logic uses the synchronized value (rx_s).
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP, with a bit-timing counter and a 3-bit bit index.
REQ-012 IDLE: on rx_s == 0, SHALL go to START, clear the counter and assert rx_busy.
REQ-013 START: at counter == CLKS_PER_BIT/2-1, SHALL sample rx_s.
REQ-014 START: if the sample is 0, SHALL go to DATA with the counter cleared; if 1 (glitch), SHALL return to IDLE with no output pulse.
REQ-015 DATA: SHALL sample rx_s every CLKS_PER_BIT cycles (mid-bit) into a shift register, LSB first, 8 bits.
REQ-016 DATA: after bit index 7, SHALL go to PARITY if parity is compiled in, else to STOP.
REQ-017 STOP: at mid-bit, if rx_s == 1, SHALL load data from the shift register and pulse rx_valid the next cycle.
REQ-018 STOP: at mid-bit, if rx_s == 0, SHALL pulse frame_err the next cycle and leave data unchanged.
REQ-019 In either STOP case, SHALL enter IDLE in the same cycle the pulse asserts.
REQ-020 SHALL make rx_busy low in IDLE and high in every other state.
REQ-021 SHALL not hold the remaining half stop bit; a start edge from the following frame SHALL be accepted once IDLE is entered, so back-to-back frames receive without loss.
REQ-022 SHALL keep rx_valid, frame_err and parity_err mutually exclusive; each SHALL be high for exactly one cycle per frame.
REQ-023 SHALL make the counter wrap exactly at CLKS_PER_BIT-1 in DATA, PARITY and STOP, so sample points drift by no cycles across the frame.
REQ-024 An rx transition between sample points SHALL have no effect outside IDLE.

Reset
REQ-025 When reset is high at a clock edge, SHALL go to IDLE, clear the counter, bit index and shift register, and set the synchronizer flops to 1.
REQ-026 Reset SHALL drive data=8'h00, rx_valid=0, rx_busy=0, frame_err=0, parity_err=0.
REQ-027 Reset mid-frame SHALL abort the frame with no pulse; reception SHALL restart on the next falling edge after reset deasserts.

Configuration
REQ-028 SHALL use macro UART_RX_PARITY_EN.
REQ-029 With UART_RX_PARITY_EN defined: SHALL expect one even-parity bit between the data and stop bits (PARITY state, mid-bit sample).
REQ-030 With parity compiled in: on mismatch with a valid stop bit, SHALL pulse parity_err instead of rx_valid and leave data unchanged; frame_err SHALL take priority over parity_err.
REQ-031 Without UART_RX_PARITY_EN: the frame SHALL be 8N1, the PARITY state SHALL be absent, and parity_err SHALL be tied 0.

Structure
REQ-032 Package uart_pkg SHALL hold the rx state enum typedef, DATA_BITS=8, and the default CLKS_PER_BIT constant, shared with uart_tx.
REQ-033 The synchronizer SHALL be a separate sub-module, uart_rx_sync (2-flop, reset value 1).

Verification (CLKS_PER_BIT=10)
REQ-034 8N1 frame for 8'hA5 -> one rx_valid pulse, data=8'hA5, frame_err=0, rx_busy high from the start edge (+2 sync cycles) to the pulse.
REQ-035 rx low for 3 cycles, then high -> rx_busy pulses briefly, then no rx_valid, frame_err or parity_err, and data unchanged.
REQ-036 Frame 8'h3C with stop bit driven low -> frame_err one cycle, no rx_valid, data keeps its previous value.
REQ-037 Back-to-back frames 8'h55 then 8'hFF with no idle gap -> two rx_valid pulses in order, data=8'h55 then 8'hFF.
REQ-038 reset asserted at data bit 4 of a frame, then a full frame 8'h81 -> no pulse for the aborted frame; 8'h81 received correctly.
REQ-039 With UART_RX_PARITY_EN: frame 8'h07 with parity bit 0 (wrong) -> parity_err one cycle, no rx_valid; with parity bit 1 -> rx_valid, data=8'h07.
